// File: rtl/bldc_commutation_controller.sv
// Six-step BLDC commutation: hall sector + direction -> dead-timed, PWM-gated bridge pattern with
// sticky invalid-hall/stall faults. Optional brake via `BLDC_COMMUTATION_BRAKE_EN. direction_cmd: 01 CW, 10 CCW, else coast.
module bldc_commutation_controller #(
    parameter int clk_freq_hz        = 27_000_000,
    parameter int dead_time_ticks    = 27,
    parameter int invalid_hall_ticks = 270,
    parameter int stall_ms           = 500,
    parameter int timer_width        = 32
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] direction_cmd,
    input  logic [2:0] sector,
    input  logic       pwm,
    input  logic       brake,
    output logic [2:0] gate_hi,
    output logic [2:0] gate_lo,
    output logic [2:0] state,
    output logic       fault_invalid_hall,
    output logic       fault_stall
);
    localparam logic [1:0]             DIR_CW    = 2'b01;
    localparam logic [1:0]             DIR_CCW   = 2'b10;
    localparam logic [timer_width-1:0] DT_LAST   = timer_width'(dead_time_ticks - 1);
    localparam logic [timer_width-1:0] INV_LIM   = timer_width'(invalid_hall_ticks);
    localparam logic [timer_width-1:0] STALL_LIM = timer_width'(clk_freq_hz / 1000 * stall_ms);
    localparam logic [timer_width-1:0] CNT_MAX   = '1;
    // Patterns are packed {lo[2:0], hi[2:0]}
    localparam logic [5:0]             PAT_OFF   = 6'b000_000;
    localparam logic [5:0]             PAT_BRAKE = 6'b111_000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEAD  = 3'd1,
        S_RUN   = 3'd2,
        S_BRAKE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             tgt_q, tgt_d, target;
    logic [timer_width-1:0] dcnt_q, dcnt_d, inv_cnt_q, inv_cnt_d, stall_cnt_q, stall_cnt_d;
    logic [2:0]             sector_prev_q, hi_q, hi_d, lo_q, lo_d, ccw_idx;
    logic                   fi_q, fi_d, fs_q, fs_d, inv_hit, stall_hit, brake_req;

    function automatic logic [5:0] cw_pat(input logic [2:0] s);
        case (s)
            3'd0:    cw_pat = {3'b010, 3'b001};
            3'd1:    cw_pat = {3'b100, 3'b001};
            3'd2:    cw_pat = {3'b100, 3'b010};
            3'd3:    cw_pat = {3'b001, 3'b010};
            3'd4:    cw_pat = {3'b001, 3'b100};
            3'd5:    cw_pat = {3'b010, 3'b100};
            default: cw_pat = PAT_OFF;
        endcase
    endfunction

    function automatic logic [timer_width-1:0] sat_inc(input logic [timer_width-1:0] v);
        return (v == CNT_MAX) ? v : v + timer_width'(1);
    endfunction

`ifdef BLDC_COMMUTATION_BRAKE_EN
    assign brake_req = brake;
`else
    assign brake_req = brake & 1'b0;
`endif

    assign ccw_idx = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;

    always_comb begin
        target = PAT_OFF;
        if (enable) begin
            if (brake_req)
                target = PAT_BRAKE;
            else if (sector <= 3'd5 && direction_cmd == DIR_CW)
                target = cw_pat(sector);
            else if (sector <= 3'd5 && direction_cmd == DIR_CCW)
                target = cw_pat(ccw_idx);
        end
    end

    assign inv_cnt_d   = (enable && sector == 3'd7) ? sat_inc(inv_cnt_q) : '0;
    assign stall_cnt_d = (state_q == S_RUN && sector == sector_prev_q) ? sat_inc(stall_cnt_q) : '0;
    assign inv_hit     = enable && sector == 3'd7 && inv_cnt_d >= INV_LIM;
    assign stall_hit   = stall_cnt_d > STALL_LIM;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        dcnt_d  = dcnt_q;
        fi_d    = fi_q;
        fs_d    = fs_q;
        if (state_q == S_FAULT) begin
            if (!enable) begin
                state_d = S_IDLE;
                fi_d    = 1'b0;
                fs_d    = 1'b0;
            end
        end else if (inv_hit || stall_hit) begin
            state_d = S_FAULT;
            tgt_d   = PAT_OFF;
            dcnt_d  = '0;
            fi_d    = fi_q | inv_hit;
            fs_d    = fs_q | stall_hit;
        end else begin
            case (state_q)
                S_IDLE: if (target != PAT_OFF) begin
                    state_d = S_DEAD;
                    tgt_d   = target;
                    dcnt_d  = '0;
                end
                // A target change mid dead time restarts the full dead interval
                S_DEAD: if (target != tgt_q) begin
                    tgt_d  = target;
                    dcnt_d = '0;
                end else if (dcnt_q >= DT_LAST) begin
                    dcnt_d = '0;
                    if (tgt_q == PAT_OFF)        state_d = S_IDLE;
                    else if (tgt_q == PAT_BRAKE) state_d = S_BRAKE;
                    else                         state_d = S_RUN;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                end
                S_RUN, S_BRAKE: if (target != tgt_q) begin
                    state_d = S_DEAD;
                    tgt_d   = target;
                    dcnt_d  = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Gates follow the next state so only RUN/BRAKE ever drive; hi is masked by lo as a last guard
    always_comb begin
        hi_d = 3'b000;
        lo_d = 3'b000;
        if (state_d == S_RUN) begin
            lo_d = tgt_d[5:3];
            hi_d = tgt_d[2:0] & {3{pwm}} & ~tgt_d[5:3];
        end else if (state_d == S_BRAKE) begin
            lo_d = 3'b111;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tgt_q         <= PAT_OFF;
            dcnt_q        <= '0;
            inv_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            sector_prev_q <= 3'd0;
            hi_q          <= 3'b000;
            lo_q          <= 3'b000;
            fi_q          <= 1'b0;
            fs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            dcnt_q        <= dcnt_d;
            inv_cnt_q     <= inv_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            sector_prev_q <= sector;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            fi_q          <= fi_d;
            fs_q          <= fs_d;
        end
    end

    assign gate_hi            = hi_q;
    assign gate_lo            = lo_q;
    assign state              = state_q;
    assign fault_invalid_hall = fi_q;
    assign fault_stall        = fs_q;
endmodule

// File: tb/tb_bldc_commutation_controller.sv
// Scoreboard bench for bldc_commutation_controller: each driven cycle queues the expected
// outputs for the following edge; a monitor pops and compares them and checks no phase shoots through.
module tb_bldc_commutation_controller;
    localparam int DT        = 4;
    localparam int INV       = 8;
    localparam int FREQ      = 200_000;
    localparam int SMS       = 1;
    localparam int STALL_LIM = FREQ / 1000 * SMS;

    localparam logic [1:0] CW   = 2'b01;
    localparam logic [1:0] CCW  = 2'b10;
    localparam logic [1:0] NONE = 2'b00;

    logic       sys_clk = 1'b0;
    logic       reset_n, enable, pwm, brake;
    logic [1:0] direction_cmd;
    logic [2:0] sector;
    logic [2:0] gate_hi, gate_lo, state;
    logic       fault_invalid_hall, fault_stall;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] hi;
        logic [2:0] lo;
        logic       fi;
        logic       fs;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_chk = 0;
    int    n_err = 0;

    bldc_commutation_controller #(
        .clk_freq_hz       (FREQ),
        .dead_time_ticks   (DT),
        .invalid_hall_ticks(INV),
        .stall_ms          (SMS),
        .timer_width       (32)
    ) dut (
        .sys_clk           (sys_clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .direction_cmd     (direction_cmd),
        .sector            (sector),
        .pwm               (pwm),
        .brake             (brake),
        .gate_hi           (gate_hi),
        .gate_lo           (gate_lo),
        .state             (state),
        .fault_invalid_hall(fault_invalid_hall),
        .fault_stall       (fault_stall)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk) begin
        exp_t  e;
        string t;
        #1;
        chk("no_shoot", 32'(gate_hi & gate_lo), 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".st"}, 32'(state), 32'(e.st));
            chk({t, ".hi"}, 32'(gate_hi), 32'(e.hi));
            chk({t, ".lo"}, 32'(gate_lo), 32'(e.lo));
            chk({t, ".fi"}, 32'(fault_invalid_hall), 32'(e.fi));
            chk({t, ".fs"}, 32'(fault_stall), 32'(e.fs));
        end
    end

    // Queue the outputs expected after the next edge, then step to the drive window (edge + 2)
    task automatic cyc(input string tag, input logic [2:0] st, input logic [2:0] hi,
                       input logic [2:0] lo, input logic fi = 1'b0, input logic fs = 1'b0);
        exp_t e;
        e.st = st; e.hi = hi; e.lo = lo; e.fi = fi; e.fs = fs;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge sys_clk);
        #2;
    endtask

    task automatic dead(input string tag);
        repeat (DT) cyc(tag, 3'd1, 3'b000, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; pwm = 1'b0; brake = 1'b0;
        direction_cmd = NONE; sector = 3'd0;
        #3;
        chk("rst.st", 32'(state), 32'd0);
        chk("rst.hi", 32'(gate_hi), 32'd0);
        chk("rst.lo", 32'(gate_lo), 32'd0);
        chk("rst.fi", 32'(fault_invalid_hall), 32'd0);
        chk("rst.fs", 32'(fault_stall), 32'd0);
        @(posedge sys_clk); #2;
        reset_n = 1'b1;
        cyc("idle", 3'd0, 3'b000, 3'b000);

        // Start-up CW sector 0
        enable = 1'b1; direction_cmd = CW; sector = 3'd0; pwm = 1'b1;
        dead("t1.dead");
        cyc("t1.run", 3'd2, 3'b001, 3'b010);
        cyc("t1.run", 3'd2, 3'b001, 3'b010);

        // Commutate 0 -> 1
        sector = 3'd1;
        dead("t2.dead");
        cyc("t2.run", 3'd2, 3'b001, 3'b100);

        // CCW sector 0 uses CW sector 3; PWM gates high side with one cycle lag
        direction_cmd = CCW; sector = 3'd0;
        dead("t3.dead");
        cyc("t3.run", 3'd2, 3'b010, 3'b001);
        pwm = 1'b0; cyc("t3.pwm0", 3'd2, 3'b000, 3'b001);
        pwm = 1'b1; cyc("t3.pwm1", 3'd2, 3'b010, 3'b001);
        pwm = 1'b0; cyc("t3.pwm0b", 3'd2, 3'b000, 3'b001);
        pwm = 1'b1; cyc("t3.pwm1b", 3'd2, 3'b010, 3'b001);

        // Sector change in the second dead cycle restarts the dead interval
        sector = 3'd1;
        cyc("t6.dead_a", 3'd1, 3'b000, 3'b000);
        cyc("t6.dead_a", 3'd1, 3'b000, 3'b000);
        sector = 3'd2;
        dead("t6.dead_b");
        cyc("t6.run", 3'd2, 3'b100, 3'b010);

        // Brake request in RUN
        brake = 1'b1;
`ifdef BLDC_COMMUTATION_BRAKE_EN
        dead("t5.dead");
        cyc("t5.brake", 3'd3, 3'b000, 3'b111);
        cyc("t5.brake", 3'd3, 3'b000, 3'b111);
        brake = 1'b0;
        dead("t5.rel_dead");
        cyc("t5.rel_run", 3'd2, 3'b100, 3'b010);
`else
        repeat (3) cyc("t5.nobrake", 3'd2, 3'b100, 3'b010);
        brake = 1'b0;
        cyc("t5.run", 3'd2, 3'b100, 3'b010);
`endif

        // Invalid hall: off-target dead time, IDLE, then fault on the INV-th cycle
        sector = 3'd7;
        dead("t4.dead");
        repeat (INV - DT - 1) cyc("t4.idle", 3'd0, 3'b000, 3'b000);
        cyc("t4.fault", 3'd4, 3'b000, 3'b000, 1'b1);
        sector = 3'd2;
        cyc("t4.hold", 3'd4, 3'b000, 3'b000, 1'b1);
        cyc("t4.hold", 3'd4, 3'b000, 3'b000, 1'b1);
        enable = 1'b0;
        cyc("t4.clear", 3'd0, 3'b000, 3'b000);

        // Stall: RUN with a frozen sector faults once the count exceeds the limit
        enable = 1'b1; direction_cmd = CW; sector = 3'd0;
        dead("st.dead");
        repeat (STALL_LIM + 1) cyc("st.run", 3'd2, 3'b001, 3'b010);
        cyc("st.fault", 3'd4, 3'b000, 3'b000, 1'b0, 1'b1);
        enable = 1'b0;
        cyc("st.clear", 3'd0, 3'b000, 3'b000);

        // Asynchronous reset mid-RUN
        enable = 1'b1;
        dead("ar.dead");
        cyc("ar.run", 3'd2, 3'b001, 3'b010);
        reset_n = 1'b0;
        #1;
        chk("ar.hi", 32'(gate_hi), 32'd0);
        chk("ar.lo", 32'(gate_lo), 32'd0);
        chk("ar.st", 32'(state), 32'd0);
        @(posedge sys_clk); #2;
        enable = 1'b0;
        reset_n = 1'b1;
        cyc("ar.idle", 3'd0, 3'b000, 3'b000);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
